// File: rtl/verinject_seq_pkg.sv
// Purpose: shared types and constants for the verinject injection sequencer.
// Latency: n/a (package only).
// Backpressure: n/a; holds the mode/state enums, LFSR taps and the idle-code helper.
package verinject_seq_pkg;

  // Campaign modes as presented on the mode port; 2'd3 is reserved and rejected.
  typedef enum logic [1:0] {
    MODE_SWEEP  = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_RANDOM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PICK   = 2'd1,
    ST_INJECT = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned MAX_STATE_W = 64;

  // All-ones is the "no injection" code; callers cast down to their own width.
  function automatic logic [MAX_STATE_W-1:0] idle_value();
    return '1;
  endfunction

endpackage

// File: rtl/verinject_inject_sequencer_lfsr16.sv
// Purpose: 16-bit Galois LFSR used to draw random-mode bit indices.
// Latency: new value visible the cycle after advance is sampled.
// Backpressure: none; holds its value whenever advance is low.
// Ports: clk, rst (sync, active-high, reloads SEED), advance, lfsr (current state).
module verinject_lfsr16
  import verinject_seq_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (advance) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
    end
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/verinject_inject_sequencer.sv
// Purpose: drives the injector state word through sweep, single-shot or random campaigns.
// Latency: first injected index one cycle after start is sampled (random adds >=1 pick cycle).
// Backpressure: none; stop aborts to idle next cycle, start is only honoured while idle.
// Ports: clk/rst, start/stop/mode/loop, lo/hi/range_mask indices, dwell/gap/n_slots counts;
//        outputs inject_state (all-ones = idle), busy, done/err pulses, inj_count.
module verinject_inject_sequencer
  import verinject_seq_pkg::*;
#(
  parameter int unsigned STATE_W   = 32,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               loop,
  input  logic [STATE_W-1:0] lo_index,
  input  logic [STATE_W-1:0] hi_index,
  input  logic [STATE_W-1:0] range_mask,
  input  logic [CNT_W-1:0]   dwell,
  input  logic [CNT_W-1:0]   gap,
  input  logic [CNT_W-1:0]   n_slots,
  output logic [STATE_W-1:0] inject_state,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STATE_W-1:0] inj_count
);

  state_e             r_state;
  logic [1:0]         r_mode;
  logic               r_loop;
  logic [STATE_W-1:0] r_lo, r_hi, r_mask, r_cur;
  logic [CNT_W-1:0]   r_dwell_m1, r_gap, r_slots, r_cnt;
  logic [STATE_W-1:0] r_inject_state, r_inj_count;
  logic               r_busy, r_done, r_err;

  logic [STATE_W-1:0] w_ones;
  logic [15:0]        w_lfsr;
  logic [STATE_W:0]   w_cand;
  logic [STATE_W-1:0] w_slots_done;

  state_e             w_state_nxt, w_dec_state;
  logic [STATE_W-1:0] w_cur_nxt, w_dec_cur;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_dec_finish, w_take_dec, w_done_nxt, w_err_nxt;
  logic               w_latch, w_count_inc, w_advance;

  assign w_ones = STATE_W'(idle_value());

  verinject_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (w_advance),
    .lfsr    (w_lfsr)
  );

  // Extra top bit catches lo + offset overflowing STATE_W; such picks are rejected.
  assign w_cand = {1'b0, r_lo} + {1'b0, ({{(STATE_W-16){1'b0}}, w_lfsr} & r_mask)};

  // Slots finished including the one that completes this cycle when leaving INJECT.
  assign w_slots_done = r_inj_count + ((r_state == ST_INJECT) ? STATE_W'(1) : '0);

  // What follows a completed injection (after its gap, if any).
  always_comb begin
    w_dec_state  = ST_IDLE;
    w_dec_cur    = r_cur;
    w_dec_finish = 1'b0;
    case (r_mode)
      MODE_SWEEP: begin
        // Compare before incrementing so cur never steps past hi into the idle code.
        if (r_cur < r_hi) begin
          w_dec_state = ST_INJECT;
          w_dec_cur   = r_cur + STATE_W'(1);
        end else if (r_loop) begin
          w_dec_state = ST_INJECT;
          w_dec_cur   = r_lo;
        end else begin
          w_dec_finish = 1'b1;
        end
      end
      MODE_RANDOM: begin
        if (w_slots_done < STATE_W'(r_slots)) w_dec_state = ST_PICK;
        else                                  w_dec_finish = 1'b1;
      end
      default: w_dec_finish = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    w_take_dec  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;
    w_count_inc = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          if ((mode == 2'd3) || (lo_index > hi_index)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_cur_nxt   = lo_index;
            w_cnt_nxt   = (dwell == '0) ? '0 : dwell - CNT_W'(1);
            w_state_nxt = (mode == MODE_RANDOM) ? ST_PICK : ST_INJECT;
          end
        end
      end
      ST_PICK: begin
        w_advance = 1'b1;
        if (w_cand <= {1'b0, r_hi}) begin
          w_state_nxt = ST_INJECT;
          w_cur_nxt   = w_cand[STATE_W-1:0];
          w_cnt_nxt   = r_dwell_m1;
        end
      end
      ST_INJECT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_count_inc = 1'b1;
          if (r_gap != '0) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = r_gap - CNT_W'(1);
          end else begin
            w_take_dec = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_cnt != '0) w_cnt_nxt  = r_cnt - CNT_W'(1);
        else             w_take_dec = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_take_dec) begin
      w_state_nxt = w_dec_state;
      w_cur_nxt   = w_dec_cur;
      w_cnt_nxt   = r_dwell_m1;
      w_done_nxt  = w_dec_finish;
    end

    // Abort: no done pulse, and a completing injection is not counted.
    if (stop && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
      w_count_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_mode         <= 2'd0;
      r_loop         <= 1'b0;
      r_lo           <= '0;
      r_hi           <= '0;
      r_mask         <= '0;
      r_cur          <= '0;
      r_dwell_m1     <= '0;
      r_gap          <= '0;
      r_slots        <= '0;
      r_cnt          <= '0;
      r_inject_state <= '1;
      r_inj_count    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_mode      <= mode;
        r_loop      <= loop;
        r_lo        <= lo_index;
        r_hi        <= hi_index;
        r_mask      <= range_mask;
        r_dwell_m1  <= (dwell == '0) ? '0 : dwell - CNT_W'(1);
        r_gap       <= gap;
        r_slots     <= (n_slots == '0) ? CNT_W'(1) : n_slots;
        r_inj_count <= '0;
      end else if (w_count_inc) begin
        r_inj_count <= r_inj_count + STATE_W'(1);
      end
      // Outputs are registered from the next state so they line up with it.
      r_inject_state <= (w_state_nxt == ST_INJECT) ? w_cur_nxt : w_ones;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_done         <= w_done_nxt;
      r_err          <= w_err_nxt;
    end
  end

  assign inject_state = r_inject_state;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign inj_count    = r_inj_count;

endmodule

// File: tb/tb_verinject_inject_sequencer.sv
// Purpose: self-checking bench for verinject_inject_sequencer against a campaign-level model.
// Latency: model emits one expected record per cycle starting the cycle after start.
// Backpressure: n/a; stop/reset flush the expected stream.
module tb_verinject_inject_sequencer;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop;
  logic [1:0]  mode;
  logic [31:0] lo_index, hi_index, range_mask;
  logic [15:0] dwell, gap, n_slots;
  logic [31:0] inject_state, inj_count;
  logic        busy, done, err;

  always #5 clk = ~clk;

  verinject_inject_sequencer #(.STATE_W(32), .CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .loop(loop),
    .lo_index(lo_index), .hi_index(hi_index), .range_mask(range_mask),
    .dwell(dwell), .gap(gap), .n_slots(n_slots),
    .inject_state(inject_state), .busy(busy), .done(done), .err(err),
    .inj_count(inj_count)
  );

  typedef struct {
    logic [31:0] st;
    logic        bsy;
    logic        dn;
    logic        er;
    logic [31:0] cnt;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 0;
  bit          collect = 0;
  logic [31:0] hold_cnt = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [31:0] dut_vals[$];
  logic [31:0] run1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic void push(input logic [31:0] st, input bit b, input bit d,
                               input bit e, input logic [31:0] c);
    rec_t r;
    r.st = st; r.bsy = b; r.dn = d; r.er = e; r.cnt = c;
    exp_q.push_back(r);
  endfunction

  // Expected per-cycle output stream of a whole campaign, from the mode rules.
  task automatic model_campaign(input int md, input bit lp, input logic [31:0] lo,
                                input logic [31:0] hi, input logic [31:0] mask,
                                input int dw, input int gp, input int ns, input int max_rec);
    int          dwe, nse;
    logic [31:0] c, idx;
    logic [32:0] cand;
    bit          fin;
    dwe = (dw == 0) ? 1 : dw;
    nse = (ns == 0) ? 1 : ns;
    c   = 0;
    fin = 0;
    if (md == 2) begin
      for (int s = 0; s < nse; s++) begin
        do begin
          push(ONES, 1, 0, 0, c);
          cand   = {1'b0, lo} + {1'b0, ({16'h0, m_lfsr} & mask)};
          m_lfsr = lfsr_next(m_lfsr);
        end while (cand > {1'b0, hi});
        repeat (dwe) push(cand[31:0], 1, 0, 0, c);
        c++;
        repeat (gp) push(ONES, 1, 0, 0, c);
      end
      fin = 1;
    end else begin
      idx = lo;
      while (!fin && exp_q.size() < max_rec) begin
        repeat (dwe) push(idx, 1, 0, 0, c);
        c++;
        repeat (gp) push(ONES, 1, 0, 0, c);
        if (md == 1)        fin = 1;
        else if (idx < hi)  idx = idx + 1;
        else if (lp)        idx = lo;
        else                fin = 1;
      end
    end
    if (fin) push(ONES, 0, 1, 0, c);
  endtask

  // Called on a negedge; returns on the negedge of the first post-start cycle.
  task automatic start_c(input int md, input bit lp, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [31:0] mask, input int dw,
                         input int gp, input int ns, input int max_rec, input bit stp);
    mode = 2'(md); loop = lp; lo_index = lo; hi_index = hi; range_mask = mask;
    dwell = 16'(dw); gap = 16'(gp); n_slots = 16'(ns); start = 1; stop = stp;
    if (!stp) begin
      if (md == 3 || lo > hi) push(ONES, 0, 0, 1, hold_cnt);
      else                    model_campaign(md, lp, lo, hi, mask, dw, gp, ns, max_rec);
    end
    @(negedge clk);
    start = 0; stop = 0;
    // Latched campaign parameters must ignore these.
    mode = 2'($urandom); loop = 1'($urandom); lo_index = $urandom; hi_index = $urandom;
    range_mask = $urandom; dwell = 16'($urandom_range(1, 9)); gap = 16'($urandom_range(0, 5));
    n_slots = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL wait_idle: %0d records left after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1;
    exp_q.delete();
    hold_cnt = 0;
    m_lfsr = 16'hACE1;
    @(negedge clk);
    rst = 0;
  endtask

  always @(posedge clk) begin
    rec_t r;
    #1;
    if (chk_en) begin
      if (exp_q.size() > 0) r = exp_q.pop_front();
      else begin
        r.st = ONES; r.bsy = 0; r.dn = 0; r.er = 0; r.cnt = hold_cnt;
      end
      hold_cnt = r.cnt;
      check("inject_state", inject_state, r.st);
      check("busy", 32'(busy), 32'(r.bsy));
      check("done", 32'(done), 32'(r.dn));
      check("err", 32'(err), 32'(r.er));
      check("inj_count", inj_count, r.cnt);
      if (collect && busy && inject_state !== ONES) dut_vals.push_back(inject_state);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1; start = 0; stop = 0; mode = 0; loop = 0;
    lo_index = 0; hi_index = 0; range_mask = 0; dwell = 1; gap = 0; n_slots = 1;

    // Pin the model's LFSR against hand-stepped values from seed ACE1.
    check("lfsr_step1", 32'(lfsr_next(16'hACE1)), 32'h0000_E270);
    check("lfsr_step2", 32'(lfsr_next(16'hE270)), 32'h0000_7138);

    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    check("reset_state", inject_state, ONES);
    check("reset_count", inj_count, 32'd0);
    rst = 0;
    @(negedge clk);

    // Sweep 0..2, dwell 3, no gap.
    start_c(0, 0, 0, 2, 0, 3, 0, 0, 1000, 0);
    check("sweep_c1", inject_state, 32'd0);
    repeat (9) @(negedge clk);
    check("sweep_c10_state", inject_state, ONES);
    check("sweep_c10_done", 32'(done), 32'd1);
    check("sweep_c10_count", inj_count, 32'd3);
    wait_idle(100);
    repeat (2) @(negedge clk);

    // Looping sweep 5..6, dwell 1, gap 2, aborted by stop.
    start_c(0, 1, 5, 6, 0, 1, 2, 0, 60, 0);
    check("loop_c1", inject_state, 32'd5);
    repeat (3) @(negedge clk);
    check("loop_c4", inject_state, 32'd6);
    repeat (3) @(negedge clk);
    check("loop_c7", inject_state, 32'd5);
    repeat (5) @(negedge clk);
    stop = 1;
    exp_q.delete();
    push(ONES, 0, 0, 0, hold_cnt);
    @(negedge clk);
    stop = 0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_count", inj_count, 32'd4);
    repeat (3) @(negedge clk);

    // Single shot at 96 with dwell 0.
    start_c(1, 0, 96, 96, 0, 0, 0, 0, 1000, 0);
    check("single_c1", inject_state, 32'd96);
    @(negedge clk);
    check("single_done", 32'(done), 32'd1);
    check("single_count", inj_count, 32'd1);
    wait_idle(20);
    repeat (2) @(negedge clk);

    // Rejected starts.
    start_c(0, 0, 10, 9, 0, 1, 0, 0, 1000, 0);
    check("rej_range_err", 32'(err), 32'd1);
    check("rej_range_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start_c(3, 0, 1, 4, 0, 1, 0, 0, 1000, 0);
    check("rej_mode_err", 32'(err), 32'd1);
    @(negedge clk);
    start_c(0, 0, 1, 4, 0, 1, 0, 0, 1000, 1);
    check("start_stop_busy", 32'(busy), 32'd0);
    check("start_stop_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);

    // Random campaign from a freshly seeded LFSR.
    do_reset();
    @(negedge clk);
    dut_vals.delete();
    collect = 1;
    start_c(2, 0, 0, 96, 127, 2, 0, 20, 0, 0);
    repeat (3) @(negedge clk);
    check("rand_first", inject_state, 32'd56);
    repeat (3) @(negedge clk);
    check("rand_second", inject_state, 32'd28);
    wait_idle(2000);
    collect = 0;
    check("rand_count", inj_count, 32'd20);
    check("rand_cycles", 32'(dut_vals.size()), 32'd40);
    bad = 0;
    foreach (dut_vals[i]) if (dut_vals[i] > 96) bad++;
    check("rand_range", 32'(bad), 32'd0);
    run1 = dut_vals;
    repeat (2) @(negedge clk);

    // Reset mid-injection, then rerun the same random campaign.
    do_reset();
    @(negedge clk);
    start_c(2, 0, 0, 96, 127, 2, 0, 20, 0, 0);
    repeat (7) @(negedge clk);
    do_reset();
    check("rst_mid_state", inject_state, ONES);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_count", inj_count, 32'd0);
    dut_vals.delete();
    collect = 1;
    start_c(2, 0, 0, 96, 127, 2, 0, 20, 0, 0);
    wait_idle(2000);
    collect = 0;
    check("repro_len", 32'(dut_vals.size()), 32'(run1.size()));
    bad = 0;
    foreach (dut_vals[i]) if (i < run1.size() && dut_vals[i] !== run1[i]) bad++;
    check("repro_values", 32'(bad), 32'd0);
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
